// File: rtl/lfsr_deser.sv
// Serial-to-parallel deserializer for an upstream LFSR bit stream, LSB-first,
// with a DEPTH-entry output FIFO, frame-abort and overflow pulses.
module lfsr_deser #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ser_in,
  input  logic                     ser_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  output logic                     frame_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);
  localparam logic [AW:0]   Full    = (AW + 1)'(DEPTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             frame_err_q, overflow_q;

  logic [WIDTH-1:0] word_next;
  logic             push, pop, full, wr_en;

  always_comb begin
    word_next         = sreg_q;
    word_next[cnt_q]  = ser_in;
    // Counter is only non-zero in StShift, so this covers both states.
    push              = ser_valid && (cnt_q == LastBit);
    pop               = (count_q != '0) && out_ready;
    full              = (count_q == Full);
    wr_en             = push && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sreg_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overflow_q  <= push && full && !pop;

      unique case (state_q)
        StIdle: begin
          if (ser_valid) begin
            if (push) begin
              sreg_q <= '0;
              cnt_q  <= '0;
            end else begin
              sreg_q  <= word_next;
              cnt_q   <= CW'(1);
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          if (ser_valid) begin
            if (push) begin
              sreg_q  <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              sreg_q <= word_next;
              cnt_q  <= cnt_q + CW'(1);
            end
          end else begin
            sreg_q      <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
      endcase

      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= word_next;
  end

  assign word_valid = (count_q != '0);
  assign word_out   = word_valid ? mem[rd_ptr_q] : '0;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lfsr_deser.sv
// Directed bench for lfsr_deser: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_lfsr_deser;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ser_in, ser_valid, out_ready;
  logic [W-1:0] word_out;
  logic         word_valid, frame_err, overflow;
  logic [2:0]   fifo_count;

  int errors = 0;
  int checks = 0;

  lfsr_deser #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .out_ready  (out_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: bits collected in a queue, words in a queue.
  logic         mbits [$];
  logic [W-1:0] mfifo [$];
  logic         exp_ferr, exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbits.delete();
      mfifo.delete();
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      logic         have_word, was_full, do_pop;
      logic [W-1:0] w;
      exp_ferr  = 1'b0;
      exp_ovf   = 1'b0;
      have_word = 1'b0;
      w         = '0;
      if (ser_valid) begin
        mbits.push_back(ser_in);
        if (mbits.size() == W) begin
          for (int k = 0; k < W; k++) w[k] = mbits[k];
          have_word = 1'b1;
          mbits.delete();
        end
      end else if (mbits.size() != 0) begin
        exp_ferr = 1'b1;
        mbits.delete();
      end
      was_full = (mfifo.size() == D);
      do_pop   = out_ready && (mfifo.size() != 0);
      if (do_pop) void'(mfifo.pop_front());
      if (have_word) begin
        if (was_full && !do_pop) exp_ovf = 1'b1;
        else mfifo.push_back(w);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", 32'(word_valid), 32'(mfifo.size() != 0));
      check("model_word",  32'(word_out),   32'((mfifo.size() != 0) ? mfifo[0] : '0));
      check("model_count", 32'(fifo_count), 32'(mfifo.size()));
      check("model_ferr",  32'(frame_err),  32'(exp_ferr));
      check("model_ovf",   32'(overflow),   32'(exp_ovf));
    end
  end

  task automatic cyc(input logic sv, input logic si, input logic rdy);
    ser_valid = sv;
    ser_in    = si;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], rdy);
  endtask

  initial begin
    logic [W-1:0] bits35;
    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_valid", 32'(word_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_word",  32'(word_out),   0);
    check("rst_ferr",  32'(frame_err),  0);
    check("rst_ovf",   32'(overflow),   0);
    #9 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Single word, bits 1,1,0,1,0,1,1,0 in order -> 0x6B
    bits35 = 8'b0110_1011;
    for (int i = 0; i < W; i++) cyc(1'b1, bits35[i], 1'b1);
    check("single_valid", 32'(word_valid), 1);
    check("single_word",  32'(word_out),   32'h6B);
    cyc(1'b0, 1'b0, 1'b1);
    check("single_gone", 32'(word_valid), 0);

    // Abort after 5 bits, then a clean 0xA5
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i & 1), 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("abort_ferr",  32'(frame_err),  1);
    check("abort_valid", 32'(word_valid), 0);
    cyc(1'b0, 1'b0, 1'b0);
    check("abort_ferr_pulse", 32'(frame_err), 0);
    send_word(8'hA5, 1'b0);
    check("abort_next_word",  32'(word_out),   32'hA5);
    check("abort_next_count", 32'(fifo_count), 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("abort_drained", 32'(fifo_count), 0);

    // Back-to-back words
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("b2b_count", 32'(fifo_count), 2);
    check("b2b_head0", 32'(word_out),   32'hA5);
    cyc(1'b0, 1'b0, 1'b1);
    check("b2b_head1", 32'(word_out),   32'h3C);
    cyc(1'b0, 1'b0, 1'b1);
    check("b2b_empty", 32'(fifo_count), 0);

    // Overflow on the fifth word
    for (int n = 1; n <= 5; n++) send_word(W'(n), 1'b0);
    check("ovf_pulse", 32'(overflow),   1);
    check("ovf_count", 32'(fifo_count), 4);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovf_pulse_end", 32'(overflow), 0);
    for (int n = 1; n <= 4; n++) begin
      check("ovf_drain", 32'(word_out), n);
      cyc(1'b0, 1'b0, 1'b1);
    end
    check("ovf_empty", 32'(fifo_count), 0);

    // Full with a simultaneous pop on the completing edge of 0x77
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    for (int i = 0; i < W; i++) cyc(1'b1, 1'((8'h77 >> i) & 1), (i == W - 1));
    check("fullpop_ovf",   32'(overflow),   0);
    check("fullpop_count", 32'(fifo_count), 4);
    check("fullpop_head",  32'(word_out),   32'h22);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("fullpop_last", 32'(word_out), 32'h77);
    cyc(1'b0, 1'b0, 1'b1);
    check("fullpop_empty", 32'(fifo_count), 0);

    // Reset mid-word with two stored words
    send_word(8'h5A, 1'b0);
    send_word(8'h0F, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(word_valid), 0);
    check("midrst_count", 32'(fifo_count), 0);
    check("midrst_word",  32'(word_out),   0);
    check("midrst_ferr",  32'(frame_err),  0);
    ser_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("postrst_ferr", 32'(frame_err), 0);
    send_word(8'hC3, 1'b0);
    check("postrst_count", 32'(fifo_count), 1);
    check("postrst_word",  32'(word_out),   32'hC3);
    cyc(1'b0, 1'b0, 1'b1);
    check("postrst_empty", 32'(fifo_count), 0);
    cyc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
